// File: rtl/axis_block_sig_gen.sv
// axis_block_sig_gen: per-channel AXI-Stream stall detector driving deadlock-monitor block flags.
// Optional AXIS_BLOCK_STAMP_EN adds a cycle stamp of the first blocking event on first_blk_cycle.
module axis_block_sig_gen #(
  parameter int NUM_CH = 4,
  parameter int STALL_THRESH = 16,
  parameter logic [NUM_CH-1:0] DIR_MASK = 4'b1100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic [4:0]        first_blk_idx,
  output logic              first_blk_vld,
  output logic [31:0]       first_blk_cycle
);
  typedef enum logic [1:0] {IDLE, STALLING, BLOCKED} state_t;
  localparam logic [15:0] TH = 16'(STALL_THRESH);
  state_t            state   [NUM_CH];
  state_t            nxt     [NUM_CH];
  logic [15:0]       cnt     [NUM_CH];
  logic [15:0]       cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] blk_nxt;
  logic [NUM_CH-1:0] enter;
  logic [4:0]        idx_nxt;
  always_comb begin
    idx_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stall[i]   = DIR_MASK[i] ? ch_tvalid[i] & ~ch_tready[i] : ch_tready[i] & ~ch_tvalid[i];
      nxt[i]     = IDLE;
      cnt_nxt[i] = '0;
      // cnt is 0 in IDLE, so one compare covers both the IDLE and STALLING entry into BLOCKED
      if (enable && stall[i]) begin
        if (state[i] == BLOCKED) begin
          nxt[i]     = BLOCKED;
          cnt_nxt[i] = cnt[i];
        end else if (cnt[i] + 16'd1 == TH) begin
          nxt[i]     = BLOCKED;
          cnt_nxt[i] = TH;
        end else begin
          nxt[i]     = STALLING;
          cnt_nxt[i] = cnt[i] + 16'd1;
        end
      end
      blk_nxt[i] = nxt[i] == BLOCKED;
      enter[i]   = blk_nxt[i] && state[i] != BLOCKED;
    end
    for (int i = NUM_CH - 1; i >= 0; i--)
      idx_nxt = enter[i] ? 5'(i) : idx_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      axis_block_sigs <= '0;
      any_block       <= 1'b0;
      first_blk_idx   <= '0;
      first_blk_vld   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      axis_block_sigs <= blk_nxt;
      any_block       <= |blk_nxt;
      if (!first_blk_vld && |enter) begin
        first_blk_idx <= idx_nxt;
        first_blk_vld <= 1'b1;
      end
    end
  end
`ifdef AXIS_BLOCK_STAMP_EN
  logic [31:0] cyc;
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc             <= '0;
      first_blk_cycle <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (!first_blk_vld && |enter) first_blk_cycle <= cyc;
    end
  end
`else
  assign first_blk_cycle = '0;
`endif
endmodule

// File: tb/tb_axis_block_sig_gen.sv
// tb_axis_block_sig_gen: directed scoreboard bench for axis_block_sig_gen (NUM_CH=4, STALL_THRESH=16).
module tb_axis_block_sig_gen;
  typedef struct packed {
    logic [3:0] blk;
    logic       any;
    logic [4:0] idx;
    logic       vld;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  tv = '0;
  logic [3:0]  tr = '0;
  logic [3:0]  blk;
  logic        any;
  logic [4:0]  idx;
  logic        vld;
  logic [31:0] stamp;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  always #5 clk = ~clk;
  axis_block_sig_gen dut (
    .clock(clk), .reset(rst), .enable(en), .ch_tvalid(tv), .ch_tready(tr),
    .axis_block_sigs(blk), .any_block(any), .first_blk_idx(idx), .first_blk_vld(vld),
    .first_blk_cycle(stamp)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] v, input logic [3:0] r, input logic e, input logic rs,
                      input logic [3:0] eb, input logic [4:0] ei, input logic ev, input string tag);
    exp_t x;
    @(negedge clk);
    tv = v;
    tr = r;
    en = e;
    rst = rs;
    q.push_back('{blk: eb, any: |eb, idx: ei, vld: ev});
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk({tag, "_blk"}, 32'(blk), 32'(x.blk));
    chk({tag, "_any"}, 32'(any), 32'(x.any));
    chk({tag, "_idx"}, 32'(idx), 32'(x.idx));
    chk({tag, "_vld"}, 32'(vld), 32'(x.vld));
  endtask
  initial begin
    step(4'b1111, 4'b0000, 1, 1, 4'b0000, 0, 0, "reset");
    step(4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 0, "reset");
    chk("reset_stamp", stamp, 32'd0);
    // near miss on read-side ch0: 15 stalls, handshake, 15 stalls
    for (int k = 1; k <= 15; k++) step(4'b0000, 4'b0001, 1, 0, 4'b0000, 0, 0, "near1");
    step(4'b0001, 4'b0001, 1, 0, 4'b0000, 0, 0, "near_hs");
    for (int k = 1; k <= 15; k++) step(4'b0000, 4'b0001, 1, 0, 4'b0000, 0, 0, "near2");
    step(4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, "near_idle");
    // write-side stall on ch2 for 20 cycles
    for (int k = 1; k <= 20; k++)
      step(4'b0100, 4'b0000, 1, 0, k >= 16 ? 4'b0100 : 4'b0000, k >= 16 ? 5'd2 : 5'd0, k >= 16, "ws");
    step(4'b0100, 4'b0100, 1, 0, 4'b0000, 2, 1, "ws_rel");
    // ch3 blocks, then tready releases it on the same edge
    for (int k = 1; k <= 16; k++)
      step(4'b1000, 4'b0000, 1, 0, k == 16 ? 4'b1000 : 4'b0000, 2, 1, "ch3");
    step(4'b1000, 4'b1000, 1, 0, 4'b0000, 2, 1, "ch3_rel");
    // simultaneous block of ch1 (read side) and ch3 (write side)
    step(4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, "rst2");
    for (int k = 1; k <= 16; k++)
      step(4'b1000, 4'b0010, 1, 0, k == 16 ? 4'b1010 : 4'b0000, k == 16 ? 5'd1 : 5'd0, k == 16, "sim");
    step(4'b0000, 4'b0000, 1, 0, 4'b0000, 1, 1, "sim_idle");
    // enable dropped mid-stall, then a full fresh 16 cycles are needed
    for (int k = 1; k <= 10; k++) step(4'b0100, 4'b0000, 1, 0, 4'b0000, 1, 1, "en_pre");
    for (int k = 1; k <= 3; k++) step(4'b0100, 4'b0000, 0, 0, 4'b0000, 1, 1, "en_off");
    for (int k = 1; k <= 16; k++)
      step(4'b0100, 4'b0000, 1, 0, k == 16 ? 4'b0100 : 4'b0000, 1, 1, "en_post");
    step(4'b0100, 4'b0000, 0, 0, 4'b0000, 1, 1, "en_off_blk");
    for (int k = 1; k <= 16; k++)
      step(4'b0100, 4'b0000, 1, 0, k == 16 ? 4'b0100 : 4'b0000, 1, 1, "reblk");
    step(4'b0100, 4'b0000, 1, 1, 4'b0000, 0, 0, "rst_blk");
    chk("rst_blk_stamp", stamp, 32'd0);
    // stamp: stall ch0 starting at cycle 100 after reset release
    for (int k = 0; k < 100; k++) step(4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, "st_idle");
    for (int k = 1; k <= 16; k++)
      step(4'b0000, 4'b0001, 1, 0, k == 16 ? 4'b0001 : 4'b0000, 0, k == 16, "st");
`ifdef AXIS_BLOCK_STAMP_EN
    chk("stamp", stamp, 32'd115);
`else
    chk("stamp", stamp, 32'd0);
`endif
    step(4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 1, "st_rel");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_block_sig_gen.md
# axis_block_sig_gen

Cosim-side stall detector that drives the per-channel AXI-Stream block vector consumed by the deadlock monitors. It watches the tvalid/tready pair of every DUT stream port and declares a channel blocked once it has stalled for a programmable number of consecutive cycles. Its output feeds the monitors' axis_block_sigs inputs directly. It is testbench infrastructure only: registered outputs, no effect on DUT behaviour.

## Interface
- NUM_CH, default 4: number of monitored AXI-Stream channels (1..32).
- STALL_THRESH, default 16: consecutive stalled cycles before a channel is declared blocked (1..65535).
- DIR_MASK, default 4'b1100 (NUM_CH bits): bit i = 1 means channel i is a DUT output (write side); bit i = 0 means a DUT input (read side).
- clock  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  detection enable; low forces all counters and block bits to 0.
- ch_tvalid  input  NUM_CH  tvalid of each monitored channel.
- ch_tready  input  NUM_CH  tready of each monitored channel.
- axis_block_sigs  output  NUM_CH  per-channel blocked flag; reset 0.
- any_block  output  1  OR of axis_block_sigs, registered alongside it; reset 0.
- first_blk_idx  output  5  index of the first channel to block since reset; reset 0.
- first_blk_vld  output  1  sticky, set with first_blk_idx; reset 0.

## Operation
- Per-channel stall condition:
  - Write side (DIR_MASK[i] = 1): tvalid & ~tready, meaning the DUT is waiting on a full sink.
  - Read side (DIR_MASK[i] = 0): tready & ~tvalid, meaning the DUT is waiting on an empty source.
- Each channel has an FSM with states IDLE, STALLING and BLOCKED, plus a 16-bit counter cnt[i].
- IDLE: cnt = 0.
  - Stall sampled with STALL_THRESH = 1: go to BLOCKED.
  - Stall sampled with STALL_THRESH > 1: go to STALLING with cnt = 1.
- STALLING: each stalled cycle increments cnt.
  - When cnt + 1 == STALL_THRESH, go to BLOCKED and saturate cnt at STALL_THRESH.
  - A non-stalled cycle returns the channel to IDLE with cnt = 0.
- BLOCKED: axis_block_sigs[i] = 1.
  - A non-stalled cycle (a handshake tvalid & tready, or both low) returns the channel to IDLE.
- A handshake cycle is never a stall, on either side.
- first_blk_idx / first_blk_vld:
  - Latched on the first cycle any channel enters BLOCKED.
  - If several channels enter BLOCKED in the same cycle, the lowest index wins.
  - Held until reset; enable low does not clear them.
- enable low: all FSMs go to IDLE, cnt = 0, and axis_block_sigs/any_block = 0 on the next edge.
- reset: dominates enable; clears every output and state, including mid-stall and mid-BLOCKED.

## Timing
- Counting starts at edge 1. If the stall condition holds at edges 1..STALL_THRESH, axis_block_sigs[i] is high after edge STALL_THRESH and stays high while the stall persists.
- Release latency: 1 cycle. The first non-stalled sample clears the block bit at that same edge.
- any_block asserts and deasserts on the same edges as the block bits, with no extra delay.
- first_blk_vld rises at the same edge as the winning channel's block bit.
- Counter saturates and never wraps, for any stall length.

## Configuration
- AXIS_BLOCK_STAMP_EN:
  - When defined, adds a 32-bit free-running cycle counter (cleared by reset, wraps at 2^32) and an output first_blk_cycle[31:0]. That output latches the counter value at the edge where first_blk_vld rises; reset value 0.
  - When undefined, first_blk_cycle is still present but tied to 0, and no counter is built.

## Test plan
- Write-side stall: NUM_CH = 4, STALL_THRESH = 16. Hold ch2 tvalid = 1, tready = 0 for 20 cycles.
  - axis_block_sigs = 4'b0100 from edge 16; any_block = 1; first_blk_idx = 2.
- Near-miss: ch0 read-side stall for 15 cycles, then one handshake, then 15 more stall cycles.
  - axis_block_sigs[0] never asserts; cnt restarts at 0 after the handshake.
- Release: after ch3 is BLOCKED, drive tready = 1.
  - axis_block_sigs[3] clears on that same edge; first_blk_vld stays 1.
- Simultaneous block: ch1 and ch3 start stalling on the same cycle.
  - Both block bits rise together; first_blk_idx = 1.
- enable/reset mid-stall: enable = 0 at cycle 10 of a stall.
  - Outputs stay 0; after enable = 1, blocking needs a full 16 new cycles.
  - reset asserted while BLOCKED clears all outputs, including first_blk_vld, at the next edge.
- AXIS_BLOCK_STAMP_EN defined: release reset, then stall ch0 from cycle 100.
  - first_blk_cycle = 115 (counter value at the blocking edge).
